// File: rtl/concat_pkg.sv
// rtl/concat_pkg.sv - shared bank state type and count-width helper for the ping-pong concatenator
package concat_pkg;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} bank_state_t;

  function automatic int cnt_width(input int no_reg);
    return $clog2(no_reg) + 1;
  endfunction

endpackage

// File: rtl/concat_bank.sv
// rtl/concat_bank.sv - one storage bank: write port, EMPTY/FULL flag, word count, zero fill past count
module concat_bank
  import concat_pkg::*;
#(
  parameter int DATA_SIZE = 8,
  parameter int NO_REG    = 64,
  parameter int CNT_W     = cnt_width(NO_REG)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [CNT_W-1:0]     wr_addr,
  input  logic [DATA_SIZE-1:0] wr_data,
  input  logic                 close,
  input  logic [CNT_W-1:0]     close_count,
  input  logic                 rel,
  output bank_state_t          state,
  output logic [CNT_W-1:0]     count,
  output logic [DATA_SIZE-1:0] rd_data [0:NO_REG-1]
);

  localparam int AW = $clog2(NO_REG);

  logic [DATA_SIZE-1:0] mem [0:NO_REG-1];
  bank_state_t          state_nxt;
  logic [CNT_W-1:0]     count_nxt;

  // Storage is deliberately left out of reset; the count masks stale words.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    case (state)
      EMPTY: begin
        if (close) begin
          state_nxt = FULL;
          count_nxt = close_count;
        end
      end
      FULL: begin
        if (rel) begin
          state_nxt = EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NO_REG; i++) begin
      rd_data[i] = (CNT_W'(i) < count) ? mem[i] : '0;
    end
  end

endmodule

// File: rtl/concat_pingpong.sv
// rtl/concat_pingpong.sv - ping-pong word-to-block concatenator; CONCAT_FLUSH_EN enables partial-block flush
module concat_pingpong
  import concat_pkg::*;
#(
  parameter int DATA_SIZE    = 8,
  parameter int NUM_MATRICES = 1,
  parameter int NO_REG       = 64 * NUM_MATRICES,
  parameter int CNT_W        = cnt_width(NO_REG)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_SIZE-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 flush,
  output logic [DATA_SIZE-1:0] concatout [0:NO_REG-1],
  output logic [CNT_W-1:0]     out_count,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 full
);

  localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(NO_REG - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(NO_REG);

  logic                 wr_bank;
  logic                 rd_bank;
  logic [CNT_W-1:0]     write_addr;
  bank_state_t          st0, st1;
  logic [CNT_W-1:0]     cnt0, cnt1;
  logic [DATA_SIZE-1:0] rd0 [0:NO_REG-1];
  logic [DATA_SIZE-1:0] rd1 [0:NO_REG-1];
  logic                 xfer, nat_close, flush_close, close, rel;
  logic [CNT_W-1:0]     close_count;

  assign in_ready  = ((wr_bank ? st1 : st0) == EMPTY);
  assign out_valid = ((rd_bank ? st1 : st0) == FULL);
  assign full      = (st0 == FULL) && (st1 == FULL);

  assign xfer      = in_valid && in_ready;
  assign nat_close = xfer && (write_addr == LAST_ADDR);
  assign rel       = out_valid && out_ready;

`ifdef CONCAT_FLUSH_EN
  // A same-cycle word counts as pending, so it is written before the bank closes.
  assign flush_close = flush && in_ready && ((write_addr != '0) || in_valid);
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign flush_close  = 1'b0;
`endif

  assign close       = nat_close || flush_close;
  assign close_count = nat_close ? FULL_CNT : (write_addr + {{(CNT_W-1){1'b0}}, xfer});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      write_addr <= '0;
    end else begin
      if (close) begin
        wr_bank    <= ~wr_bank;
        write_addr <= '0;
      end else if (xfer) begin
        write_addr <= write_addr + 1'b1;
      end
      if (rel) begin
        rd_bank <= ~rd_bank;
      end
    end
  end

  concat_bank #(.DATA_SIZE(DATA_SIZE), .NO_REG(NO_REG), .CNT_W(CNT_W)) u_bank0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (xfer && !wr_bank),
    .wr_addr     (write_addr),
    .wr_data     (in_data),
    .close       (close && !wr_bank),
    .close_count (close_count),
    .rel         (rel && !rd_bank),
    .state       (st0),
    .count       (cnt0),
    .rd_data     (rd0)
  );

  concat_bank #(.DATA_SIZE(DATA_SIZE), .NO_REG(NO_REG), .CNT_W(CNT_W)) u_bank1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (xfer && wr_bank),
    .wr_addr     (write_addr),
    .wr_data     (in_data),
    .close       (close && wr_bank),
    .close_count (close_count),
    .rel         (rel && rd_bank),
    .state       (st1),
    .count       (cnt1),
    .rd_data     (rd1)
  );

  always_comb begin
    out_count = out_valid ? (rd_bank ? cnt1 : cnt0) : '0;
    for (int i = 0; i < NO_REG; i++) begin
      concatout[i] = out_valid ? (rd_bank ? rd1[i] : rd0[i]) : '0;
    end
  end

endmodule

// File: tb/tb_concat_pingpong.sv
// tb/tb_concat_pingpong.sv - self-checking bench for concat_pingpong; flush cases built when CONCAT_FLUSH_EN is defined
module tb_concat_pingpong;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       flush;
  logic [7:0] concatout [0:63];
  logic [6:0] out_count;
  logic       out_valid;
  logic       out_ready;
  logic       full;

  concat_pingpong dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .concatout (concatout),
    .out_count (out_count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .full      (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: completed blocks waiting for the consumer, plus the block being filled.
  typedef struct {
    logic [7:0] w [0:63];
    int         n;
  } blk_t;

  blk_t       done_q[$];
  logic [7:0] cur[$];
  logic       s_ov, s_ir;

  typedef struct {
    int         n;
    int         mode;
    logic [7:0] base;
    logic       vld;
    logic       ordy;
    logic       e_ov, e_full, e_ir;
    logic [7:0] e_w0, e_w63;
    logic [6:0] e_cnt;
  } row_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    done_q.delete();
    cur.delete();
  endtask

  task automatic cycle(input logic v, input logic [7:0] d, input logic o, input logic f);
    logic       rdy, ov, wr, cl;
    int         nbad;
    logic [7:0] ew;
    logic [6:0] ecnt;
    blk_t       b;
    in_valid  = v;
    in_data   = d;
    out_ready = o;
    flush     = f;
    #1;
    rdy  = (done_q.size() < 2);
    ov   = (done_q.size() > 0);
    s_ov = out_valid;
    s_ir = in_ready;
    ecnt = 7'd0;
    if (ov) ecnt = 7'(done_q[0].n);
    chk("in_ready", in_ready, rdy);
    chk("out_valid", out_valid, ov);
    chk("full", full, done_q.size() == 2);
    chk("out_count", out_count, ecnt);
    nbad = 0;
    for (int i = 0; i < 64; i++) begin
      ew = 8'h00;
      if (ov) ew = done_q[0].w[i];
      if (concatout[i] !== ew) nbad++;
    end
    chk("concatout_bad_words", nbad, 0);
    @(posedge clk);
    wr = v && rdy;
    if (wr) cur.push_back(d);
    cl = wr && (cur.size() == 64);
`ifdef CONCAT_FLUSH_EN
    if (!cl && f && rdy && cur.size() > 0) cl = 1'b1;
`endif
    if (ov && o) b = done_q.pop_front();
    if (cl) begin
      for (int i = 0; i < 64; i++) b.w[i] = (i < cur.size()) ? cur[i] : 8'h00;
      b.n = cur.size();
      done_q.push_back(b);
      cur.delete();
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  function automatic logic [7:0] gen(input int mode, input logic [7:0] base, input int k);
    logic [31:0] kk;
    kk = k;
    case (mode)
      0:       return base + kk[7:0];
      1:       return base;
      default: return kk[1] ? 8'h05 : 8'h00;
    endcase
  endfunction

  row_t rows [9];

  initial begin
    int ov_cycles, run, max_run, drops;

    rows[0] = '{64, 0, 8'h00, 1, 0, 1, 0, 1, 8'h00, 8'h3F, 7'd64};
    rows[1] = '{64, 0, 8'h40, 1, 0, 1, 1, 0, 8'h00, 8'h3F, 7'd64};
    rows[2] = '{ 3, 1, 8'hAA, 1, 0, 1, 1, 0, 8'h00, 8'h3F, 7'd64};
    rows[3] = '{ 1, 1, 8'hAA, 1, 1, 1, 0, 1, 8'h40, 8'h7F, 7'd64};
    rows[4] = '{ 1, 1, 8'hAA, 1, 1, 0, 0, 1, 8'h00, 8'h00, 7'd0};
    rows[5] = '{63, 2, 8'h00, 1, 0, 1, 0, 1, 8'hAA, 8'h05, 7'd64};
    rows[6] = '{ 1, 1, 8'h00, 0, 1, 0, 0, 1, 8'h00, 8'h00, 7'd0};
    rows[7] = '{64, 2, 8'h00, 1, 0, 1, 0, 1, 8'h00, 8'h05, 7'd64};
    rows[8] = '{ 1, 1, 8'h00, 0, 1, 0, 0, 1, 8'h00, 8'h00, 7'd0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    flush     = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_full", full, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_concatout0", concatout[0], 0);

    for (int r = 0; r < 9; r++) begin
      for (int k = 0; k < rows[r].n; k++) begin
        cycle(rows[r].vld, gen(rows[r].mode, rows[r].base, k), rows[r].ordy, 1'b0);
      end
      #1;
      chk($sformatf("row%0d_out_valid", r), out_valid, rows[r].e_ov);
      chk($sformatf("row%0d_full", r), full, rows[r].e_full);
      chk($sformatf("row%0d_in_ready", r), in_ready, rows[r].e_ir);
      chk($sformatf("row%0d_word0", r), concatout[0], rows[r].e_w0);
      chk($sformatf("row%0d_word63", r), concatout[63], rows[r].e_w63);
      chk($sformatf("row%0d_out_count", r), out_count, rows[r].e_cnt);
    end

    // Sustained streaming with an always-ready consumer.
    do_reset();
    ov_cycles = 0; run = 0; max_run = 0; drops = 0;
    for (int k = 0; k < 258; k++) begin
      cycle(k < 256, 8'($urandom), 1'b1, 1'b0);
      if (!s_ir) drops++;
      if (s_ov) begin
        ov_cycles++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
    end
    chk("stream_in_ready_drops", drops, 0);
    chk("stream_out_valid_cycles", ov_cycles, 4);
    chk("stream_out_valid_run", max_run, 1);

    // Asynchronous reset in the middle of a partial block with a block presented.
    do_reset();
    for (int k = 0; k < 74; k++) cycle(1'b1, 8'(k + 3), 1'b0, 1'b0);
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_full", full, 0);
    chk("async_rst_out_count", out_count, 0);
    chk("async_rst_in_ready", in_ready, 1);
    chk("async_rst_concatout0", concatout[0], 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 8'h5A, 1'b0, 1'b0);
    for (int k = 1; k < 64; k++) cycle(1'b1, 8'(k), 1'b0, 1'b0);
    #1;
    chk("post_rst_word0", concatout[0], 8'h5A);
    chk("post_rst_out_valid", out_valid, 1);

`ifdef CONCAT_FLUSH_EN
    do_reset();
    for (int k = 0; k < 5; k++) cycle(1'b1, 8'(8'h11 + k), 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    #1;
    chk("flush_out_valid", out_valid, 1);
    chk("flush_out_count", out_count, 5);
    chk("flush_word0", concatout[0], 8'h11);
    chk("flush_word4", concatout[4], 8'h15);
    chk("flush_word5", concatout[5], 8'h00);
    chk("flush_word63", concatout[63], 8'h00);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    chk("flush_empty_out_valid", out_valid, 0);
`endif

    // Randomised traffic against the model.
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      cycle($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) < 4,
            $urandom_range(0, 19) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
